// File: rtl/mau_pkg.sv
// Shared definitions for the MEM-stage memory access unit: op encodings,
// FSM states and parameter defaults.
package mau_pkg;
  localparam int          AW_DEF       = 16;
  localparam int          DW_DEF       = 16;
  localparam logic [15:0] SP_INIT_DEF  = 16'h0FFF;
  localparam logic [15:0] SP_LIMIT_DEF = 16'h0800;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_LOAD   = 3'd1,
    OP_STORE  = 3'd2,
    OP_PUSH16 = 3'd3,
    OP_POP16  = 3'd4,
    OP_PUSH32 = 3'd5,
    OP_POP32  = 3'd6
  } op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR1  = 3'd1,
    WR2  = 3'd2,
    RD1  = 3'd3,
    RD2  = 3'd4,
    CAP  = 3'd5,
    DONE = 3'd6
  } state_e;
endpackage

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory initiator. Breaks one pipeline request into single
// word accesses and owns the downward-growing stack pointer.
// Optional macro MAU_STACK_CHECK_EN: adds stack_err and suppresses pushes
// below SP_LIMIT / pops above SP_INIT instead of wrapping.
module mem_access_unit import mau_pkg::*; #(
  parameter int            AW      = AW_DEF,
  parameter int            DW      = DW_DEF,
  parameter logic [AW-1:0] SP_INIT = AW'(SP_INIT_DEF)
`ifdef MAU_STACK_CHECK_EN
  , parameter logic [AW-1:0] SP_LIMIT = AW'(SP_LIMIT_DEF)
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [AW-1:0]   req_addr,
  input  logic [2*DW-1:0] req_wdata,
  output logic            resp_valid,
  output logic [2*DW-1:0] resp_data,
  output logic            busy,
  output logic [AW-1:0]   sp,
  output logic            mem_read,
  output logic            mem_write,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
`ifdef MAU_STACK_CHECK_EN
  , output logic          stack_err
`endif
);

  localparam logic [AW-1:0] ONE = AW'(1);
  localparam logic [AW-1:0] TWO = AW'(2);

  state_e        state;
  op_e           op_q;
  logic [DW-1:0] wlo_q;   // low half of PUSH32 data, written in WR2
  logic [DW-1:0] lo_q;    // low word of POP32, captured while RD2 strobes
  logic          err_q;   // current op was rejected by the stack check
  logic          chk_err;

  assign busy = ~req_ready;

`ifdef MAU_STACK_CHECK_EN
  logic [AW:0] sp_x;
  assign sp_x = {1'b0, sp};

  // Bounds check done in AW+1 bits so the comparison itself cannot wrap
  always_comb begin
    chk_err = 1'b0;
    case (op_e'(req_op))
      OP_PUSH16: chk_err = sp_x < ({1'b0, SP_LIMIT} + 1'b1);
      OP_PUSH32: chk_err = sp_x < ({1'b0, SP_LIMIT} + 2'd2);
      OP_POP16:  chk_err = (sp_x + 1'b1) > {1'b0, SP_INIT};
      OP_POP32:  chk_err = (sp_x + 2'd2) > {1'b0, SP_INIT};
      default:   chk_err = 1'b0;
    endcase
  end

  // err_q still describes the op being completed while resp_valid is high
  assign stack_err = resp_valid & err_q;
`else
  assign chk_err = 1'b0;
`endif

  // Request sequencer: every strobe, address and response is registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= OP_NOP;
      wlo_q      <= '0;
      lo_q       <= '0;
      err_q      <= 1'b0;
      sp         <= SP_INIT;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      resp_valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          if (req_valid) begin
            op_q  <= op_e'(req_op);
            err_q <= chk_err;
            wlo_q <= req_wdata[DW-1:0];
            case (op_e'(req_op))
              OP_LOAD: begin
                state     <= RD1;
                req_ready <= 1'b0;
                mem_read  <= 1'b1;
                mem_addr  <= req_addr;
              end
              OP_STORE: begin
                state     <= WR1;
                req_ready <= 1'b0;
                mem_write <= 1'b1;
                mem_addr  <= req_addr;
                mem_wdata <= req_wdata[DW-1:0];
              end
              OP_PUSH16, OP_PUSH32: begin
                state     <= WR1;
                req_ready <= 1'b0;
                if (!chk_err) begin
                  mem_write <= 1'b1;
                  mem_addr  <= sp;
                  mem_wdata <= (op_e'(req_op) == OP_PUSH32) ? req_wdata[2*DW-1:DW]
                                                            : req_wdata[DW-1:0];
                end
              end
              OP_POP16, OP_POP32: begin
                state     <= RD1;
                req_ready <= 1'b0;
                if (!chk_err) begin
                  mem_read <= 1'b1;
                  mem_addr <= sp + ONE;
                end
              end
              default: ;  // NOP and reserved: accepted, nothing happens
            endcase
          end
        end
        WR1: begin
          if (op_q == OP_PUSH32) begin
            state <= WR2;
            if (!err_q) begin
              mem_write <= 1'b1;
              mem_addr  <= sp - ONE;
              mem_wdata <= wlo_q;
            end
          end else begin
            state      <= DONE;
            resp_valid <= 1'b1;
            req_ready  <= 1'b1;
            if (op_q == OP_PUSH16 && !err_q) sp <= sp - ONE;
          end
        end
        WR2: begin
          state      <= DONE;
          resp_valid <= 1'b1;
          req_ready  <= 1'b1;
          if (!err_q) sp <= sp - TWO;
        end
        RD1: begin
          if (op_q == OP_POP32) begin
            state <= RD2;
            if (!err_q) begin
              mem_read <= 1'b1;
              mem_addr <= sp + TWO;
            end
          end else begin
            state <= CAP;
            if (op_q == OP_POP16 && !err_q) sp <= sp + ONE;
          end
        end
        RD2: begin
          state <= CAP;
          if (!err_q) begin
            lo_q <= mem_rdata;
            sp   <= sp + TWO;
          end
        end
        CAP: begin
          state      <= DONE;
          resp_valid <= 1'b1;
          req_ready  <= 1'b1;
          if (!err_q)
            resp_data <= (op_q == OP_POP32) ? {mem_rdata, lo_q} : {{DW{1'b0}}, mem_rdata};
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a simple one-cycle-latency memory.
// Covers the default build and MAU_STACK_CHECK_EN when defined.
module tb_mem_access_unit;
  import mau_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [15:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        busy;
  logic [15:0] sp;
  logic        mem_read, mem_write;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;
`ifdef MAU_STACK_CHECK_EN
  logic        stack_err;
`endif

  logic [15:0] mem [0:65535];
  int n_cmp = 0;
  int n_bad = 0;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .busy(busy), .sp(sp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef MAU_STACK_CHECK_EN
    , .stack_err(stack_err)
`endif
  );

  always #5 clk = ~clk;

  // Memory: write at the edge ending the strobe, read data valid the next cycle
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
    if (mem_read)  mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Read and write strobes must never overlap
  always @(negedge clk) if (rst_n) chk("rw_excl", {31'b0, mem_read & mem_write}, 32'd0);

  // Present a request and return just after its acceptance edge
  task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk("ready_wait", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = d;
    @(posedge clk);
    #1 req_valid = 1'b0; req_op = 3'd0;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    repeat (2) @(negedge clk);
    // Reset state
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_busy",  {31'b0, busy}, 32'd0);
    chk("rst_sp",    {16'b0, sp}, 32'h0FFF);
    chk("rst_resp",  {31'b0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_data, 32'd0);
    chk("rst_strb",  {30'b0, mem_read, mem_write}, 32'd0);
    chk("rst_addr",  {16'b0, mem_addr}, 32'd0);
    rst_n = 1'b1;

    // STORE then LOAD
    send(3'(OP_STORE), 16'h0001, 32'h0000A05F);
    cyc(); chk("st_wr",   {31'b0, mem_write}, 32'd1);
           chk("st_addr", {16'b0, mem_addr}, 32'h0001);
           chk("st_data", {16'b0, mem_wdata}, 32'hA05F);
           chk("st_busy", {31'b0, busy}, 32'd1);
    cyc(); chk("st_resp", {31'b0, resp_valid}, 32'd1);
           chk("st_rdy",  {31'b0, req_ready}, 32'd1);
           chk("st_wr_off", {31'b0, mem_write}, 32'd0);
    send(3'(OP_LOAD), 16'h0001, 32'h0);
    cyc(); chk("ld_rd",   {31'b0, mem_read}, 32'd1);
           chk("ld_addr", {16'b0, mem_addr}, 32'h0001);
    cyc(); chk("ld_early", {31'b0, resp_valid}, 32'd0);
    cyc(); chk("ld_resp", {31'b0, resp_valid}, 32'd1);
           chk("ld_data", resp_data, 32'h0000A05F);
    cyc(); chk("ld_pulse", {31'b0, resp_valid}, 32'd0);
           chk("ld_hold", resp_data, 32'h0000A05F);

    // PUSH16 / POP16
    send(3'(OP_PUSH16), 16'h0, 32'h00001234);
    cyc(); chk("p16_addr", {16'b0, mem_addr}, 32'h0FFF);
           chk("p16_data", {16'b0, mem_wdata}, 32'h1234);
           chk("p16_sp0",  {16'b0, sp}, 32'h0FFF);
    cyc(); chk("p16_resp", {31'b0, resp_valid}, 32'd1);
           chk("p16_sp",   {16'b0, sp}, 32'h0FFE);
    send(3'(OP_POP16), 16'h0, 32'h0);
    cyc(); chk("q16_rd",   {31'b0, mem_read}, 32'd1);
           chk("q16_addr", {16'b0, mem_addr}, 32'h0FFF);
    cyc(); chk("q16_sp",   {16'b0, sp}, 32'h0FFF);
    cyc(); chk("q16_resp", {31'b0, resp_valid}, 32'd1);
           chk("q16_data", resp_data, 32'h00001234);

    // PUSH32 / POP32
    send(3'(OP_PUSH32), 16'h0, 32'hDEADBEEF);
    cyc(); chk("p32_a1", {16'b0, mem_addr}, 32'h0FFF);
           chk("p32_d1", {16'b0, mem_wdata}, 32'hDEAD);
    cyc(); chk("p32_wr2", {31'b0, mem_write}, 32'd1);
           chk("p32_a2", {16'b0, mem_addr}, 32'h0FFE);
           chk("p32_d2", {16'b0, mem_wdata}, 32'hBEEF);
           chk("p32_sp_mid", {16'b0, sp}, 32'h0FFF);
    cyc(); chk("p32_resp", {31'b0, resp_valid}, 32'd1);
           chk("p32_sp", {16'b0, sp}, 32'h0FFD);
           chk("p32_mhi", {16'b0, mem[16'h0FFF]}, 32'hDEAD);
           chk("p32_mlo", {16'b0, mem[16'h0FFE]}, 32'hBEEF);
    send(3'(OP_POP32), 16'h0, 32'h0);
    cyc(); chk("q32_a1", {16'b0, mem_addr}, 32'h0FFE);
    cyc(); chk("q32_a2", {16'b0, mem_addr}, 32'h0FFF);
           chk("q32_rd2", {31'b0, mem_read}, 32'd1);
    cyc(); chk("q32_sp", {16'b0, sp}, 32'h0FFF);
           chk("q32_early", {31'b0, resp_valid}, 32'd0);
    cyc(); chk("q32_resp", {31'b0, resp_valid}, 32'd1);
           chk("q32_data", resp_data, 32'hDEADBEEF);

    // POP32 with back-to-back STOREs held on req_valid
    send(3'(OP_PUSH32), 16'h0, 32'h11112222);
    repeat (3) cyc();
    send(3'(OP_POP32), 16'h0, 32'h0);
    req_valid = 1'b1; req_op = 3'(OP_STORE); req_addr = 16'h0040; req_wdata = 32'h5555;
    cyc(); chk("b2b_rdy1", {31'b0, req_ready}, 32'd0);
    cyc(); chk("b2b_rdy2", {31'b0, req_ready}, 32'd0);
    cyc(); chk("b2b_rdy3", {31'b0, req_ready}, 32'd0);
    cyc(); chk("b2b_rdy4", {31'b0, req_ready}, 32'd1);
           chk("b2b_resp", {31'b0, resp_valid}, 32'd1);
           chk("b2b_data", resp_data, 32'h11112222);
    cyc(); chk("b2b_st1", {31'b0, mem_write}, 32'd1);
           chk("b2b_a1", {16'b0, mem_addr}, 32'h0040);
           req_addr = 16'h0041; req_wdata = 32'h6666;
    cyc(); chk("b2b_st1r", {31'b0, resp_valid}, 32'd1);
    cyc(); chk("b2b_a2", {16'b0, mem_addr}, 32'h0041);
           chk("b2b_st2", {31'b0, mem_write}, 32'd1);
           req_valid = 1'b0; req_op = 3'd0;
    cyc(); chk("b2b_st2r", {31'b0, resp_valid}, 32'd1);
    cyc(); chk("b2b_m40", {16'b0, mem[16'h0040]}, 32'h5555);
           chk("b2b_m41", {16'b0, mem[16'h0041]}, 32'h6666);
           chk("b2b_idle", {31'b0, resp_valid}, 32'd0);

    // Reset in the middle of a PUSH32 (during WR2)
    send(3'(OP_PUSH32), 16'h0, 32'hAAAABBBB);
    cyc(); cyc();
    chk("mid_wr2", {31'b0, mem_write}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_strb", {30'b0, mem_read, mem_write}, 32'd0);
    chk("mid_sp",   {16'b0, sp}, 32'h0FFF);
    chk("mid_rdy",  {31'b0, req_ready}, 32'd1);
    cyc(); rst_n = 1'b1;
    cyc(); chk("mid_noresp1", {31'b0, resp_valid}, 32'd0);
    cyc(); chk("mid_noresp2", {31'b0, resp_valid}, 32'd0);
           chk("mid_sp2", {16'b0, sp}, 32'h0FFF);
    send(3'(OP_PUSH16), 16'h0, 32'h00007777);
    cyc(); chk("post_addr", {16'b0, mem_addr}, 32'h0FFF);
    cyc(); chk("post_sp", {16'b0, sp}, 32'h0FFE);
    send(3'(OP_POP16), 16'h0, 32'h0);
    cyc(); cyc();
    cyc(); chk("post_data", resp_data, 32'h00007777);
           chk("post_sp2", {16'b0, sp}, 32'h0FFF);

    // NOP: accepted with no activity
    send(3'(OP_NOP), 16'h0, 32'h0);
    cyc(); chk("nop_rdy", {31'b0, req_ready}, 32'd1);
           chk("nop_strb", {30'b0, mem_read, mem_write}, 32'd0);
    cyc(); chk("nop_resp", {31'b0, resp_valid}, 32'd0);

    // POP16 at sp = SP_INIT
    send(3'(OP_POP16), 16'h0, 32'h0);
`ifdef MAU_STACK_CHECK_EN
    cyc(); chk("ovf_rd", {31'b0, mem_read}, 32'd0);
    cyc(); chk("ovf_sp", {16'b0, sp}, 32'h0FFF);
    cyc(); chk("ovf_resp", {31'b0, resp_valid}, 32'd1);
           chk("ovf_err", {31'b0, stack_err}, 32'd1);
           chk("ovf_sp2", {16'b0, sp}, 32'h0FFF);
    cyc(); chk("ovf_err_off", {31'b0, stack_err}, 32'd0);
`else
    cyc(); chk("wrap_rd", {31'b0, mem_read}, 32'd1);
           chk("wrap_addr", {16'b0, mem_addr}, 32'h1000);
    cyc(); chk("wrap_sp", {16'b0, sp}, 32'h1000);
    cyc(); chk("wrap_resp", {31'b0, resp_valid}, 32'd1);
           chk("wrap_data", resp_data, 32'h00000000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
